// File: rtl/countdown_60.sv
// rtl/countdown_60.sv - BCD mm:ss countdown timer (59:59 .. 00:00) with preset, pause and done
module countdown_60 (
   input  logic       clk,
   input  logic       reset,
   input  logic       tick,
   input  logic       load,
   input  logic [7:0] load_min,
   input  logic [7:0] load_sec,
   input  logic       start,
   input  logic       pause,
   output logic [7:0] min_bcd,
   output logic [7:0] sec_bcd,
   output logic       running,
   output logic       borrow,
   output logic       done,
   output logic       expired,
   output logic       load_err
);

   typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

   state_t     state;
   logic       preset_ok;
   logic [7:0] sec_dec;
   logic [7:0] min_dec;
   logic [7:0] min_next;
   logic       sec_wrap;
   logic       count_zero;
   logic       next_zero;

   // A preset is accepted only if every digit is BCD and both tens digits are at most 5
   assign preset_ok = (load_min[7:4] <= 4'd5) && (load_min[3:0] <= 4'd9) &&
                      (load_sec[7:4] <= 4'd5) && (load_sec[3:0] <= 4'd9);

   assign count_zero = (min_bcd == 8'h00) && (sec_bcd == 8'h00);

   // One-second BCD decrement of the current count, with seconds-to-minutes borrow
   always_comb begin
      sec_wrap = 1'b0;
      sec_dec  = sec_bcd;
      min_dec  = min_bcd;
      if (sec_bcd[3:0] != 4'd0) begin
         sec_dec = {sec_bcd[7:4], sec_bcd[3:0] - 4'd1};
      end else if (sec_bcd[7:4] != 4'd0) begin
         sec_dec = {sec_bcd[7:4] - 4'd1, 4'd9};
      end else begin
         sec_dec  = 8'h59;
         sec_wrap = 1'b1;
      end
      // Minutes at 00 are held rather than wrapped; RUN never reaches that with seconds at 00
      if (min_bcd[3:0] != 4'd0) begin
         min_dec = {min_bcd[7:4], min_bcd[3:0] - 4'd1};
      end else if (min_bcd[7:4] != 4'd0) begin
         min_dec = {min_bcd[7:4] - 4'd1, 4'd9};
      end
      min_next  = sec_wrap ? min_dec : min_bcd;
      next_zero = (min_next == 8'h00) && (sec_dec == 8'h00);
   end

   // Control FSM and count registers; priority is load > pause > start > tick
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         min_bcd  <= 8'h00;
         sec_bcd  <= 8'h00;
         running  <= 1'b0;
         borrow   <= 1'b0;
         done     <= 1'b0;
         expired  <= 1'b0;
         load_err <= 1'b0;
      end else begin
         borrow   <= 1'b0;
         done     <= 1'b0;
         load_err <= 1'b0;
         if (load) begin
            if (preset_ok) begin
               min_bcd <= load_min;
               sec_bcd <= load_sec;
               state   <= IDLE;
               running <= 1'b0;
               expired <= 1'b0;
            end else begin
               load_err <= 1'b1;
            end
         end else if (pause) begin
            if (state == RUN) begin
               state   <= PAUSE;
               running <= 1'b0;
            end
         end else if (start) begin
            if (state == IDLE) begin
               if (count_zero) begin
                  state   <= DONE;
                  done    <= 1'b1;
                  expired <= 1'b1;
               end else begin
                  state   <= RUN;
                  running <= 1'b1;
               end
            end else if (state == PAUSE) begin
               state   <= RUN;
               running <= 1'b1;
            end
         end else if (tick && state == RUN) begin
            sec_bcd <= sec_dec;
            min_bcd <= min_next;
            borrow  <= sec_wrap;
            if (next_zero) begin
               state   <= DONE;
               running <= 1'b0;
               done    <= 1'b1;
               expired <= 1'b1;
            end
         end
      end
   end

endmodule
